// File: rtl/binary_to_bcd_serial.sv
// Serial double-dabble converter: one binary bit per clock, start/done handshake,
// result held stable between conversions and saturated to all-nines on overflow.
module binary_to_bcd_serial #(
    parameter int INPUT_WIDTH = 14,
    parameter int DIGIT_NUM   = 4
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset,
    input  logic                       i_Start,
    input  logic [INPUT_WIDTH-1:0]     i_Binary,
    output logic [4*DIGIT_NUM-1:0]     o_BCD_Num,
    output logic                       o_Busy,
    output logic                       o_Done,
    output logic                       o_Overflow
);

    localparam int BCD_W = 4 * DIGIT_NUM;
    localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    // Largest value representable in DIGIT_NUM decimal digits (inputs up to 64 bits).
    function automatic logic [63:0] f_max_decimal(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0]      MAX_DECIMAL = f_max_decimal(DIGIT_NUM);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(INPUT_WIDTH);
    localparam logic [BCD_W-1:0] BCD_SAT     = {DIGIT_NUM{4'h9}};

    logic [1:0]             r_state;
    logic [INPUT_WIDTH-1:0] r_shift;
    logic [BCD_W-1:0]       r_scratch;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf_flag;
    logic [BCD_W-1:0]       r_bcd;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overflow;

    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W-1:0]       w_scratch_next;
    logic [INPUT_WIDTH-1:0] w_shift_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_overflow_capt;

    // Add-3 correction is per digit; carries never cross digit boundaries.
    generate
        for (genvar gi = 0; gi < DIGIT_NUM; gi++) begin : g_digit_adj
            assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                                    ? r_scratch[4*gi +: 4] + 4'd3
                                    : r_scratch[4*gi +: 4];
        end
    endgenerate

    assign w_scratch_next  = {w_adj[BCD_W-2:0], r_shift[INPUT_WIDTH-1]};
    assign w_shift_next    = r_shift << 1;
    assign w_cnt_next      = r_cnt + 1'b1;
    assign w_overflow_capt = (64'(i_Binary) > MAX_DECIMAL);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_flag <= 1'b0;
            r_bcd      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_Start) begin
                        r_shift    <= i_Binary;
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_ovf_flag <= w_overflow_capt;
                        r_busy     <= 1'b1;
                        r_state    <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_scratch <= w_scratch_next;
                    r_shift   <= w_shift_next;
                    r_cnt     <= w_cnt_next;
                    // Output register updates only here, so the display never sees partial digits.
                    if (w_cnt_next == CNT_LAST) begin
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_bcd      <= r_ovf_flag ? BCD_SAT : w_scratch_next;
                        r_overflow <= r_ovf_flag;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_BCD_Num  = r_bcd;
    assign o_Busy     = r_busy;
    assign o_Done     = r_done;
    assign o_Overflow = r_overflow;

endmodule

// File: doc/binary_to_bcd_serial.md
# binary_to_bcd_serial

Iterative shift-add-3 (double-dabble) converter. It turns an unsigned binary count from the clock/alarm time-keeping logic into packed BCD digits. Its output feeds the `i_BCD_Num` input of the seven-segment refresh block. It converts one input bit per clock, uses a start/done handshake, and holds the last result stable between conversions so the display never sees intermediate values.

## Interface
- `INPUT_WIDTH`, 14: width of the binary input. Must be ≥ 1.
- `DIGIT_NUM`, 4: number of BCD digits produced. Output width is 4·DIGIT_NUM.
- `i_Clk`, input, 1: system clock. All logic is on the rising edge.
- `i_Reset`, input, 1: reset. Synchronous, active-high.
- `i_Start`, input, 1: conversion request. Sampled only in IDLE.
- `i_Binary`, input, INPUT_WIDTH: unsigned value. Captured on the edge that accepts `i_Start`.
- `o_BCD_Num`, output, 4·DIGIT_NUM: packed BCD. Bits [3:0] are the least-significant digit, same ordering as the refresh block. Registered.
- `o_Busy`, output, 1: high while in CONVERT. Registered.
- `o_Done`, output, 1: one-cycle pulse when `o_BCD_Num` has been updated. Registered.
- `o_Overflow`, output, 1: set with `o_Done` when the input exceeds 10^DIGIT_NUM − 1. Holds until the next `o_Done`. Registered.

## Operation
- States: IDLE, CONVERT, DONE.
- IDLE, `i_Start`=1:
  - Capture `i_Binary` into the shift register and clear the BCD scratch (4·DIGIT_NUM bits).
  - Clear the bit counter and set the overflow-compare flag from the captured value.
  - Go to CONVERT.
- IDLE, `i_Start`=0: remain in IDLE.
- CONVERT, each cycle:
  - Any scratch digit ≥ 5 has 3 added (4-bit add, no carry between digits).
  - Then {scratch, shift register} shifts left by one, so the MSB of the binary enters scratch bit 0.
  - Increment the counter.
- CONVERT exit: on the step where the counter reaches INPUT_WIDTH, load `o_BCD_Num` and `o_Overflow` and go to DONE.
  - Non-overflow load: `o_BCD_Num` = final scratch, `o_Overflow`=0.
  - Overflow load: `o_BCD_Num` = every digit 4'h9 (saturate), `o_Overflow`=1.
- DONE: lasts one cycle, then IDLE unconditionally.
- `i_Start` while in CONVERT or DONE is ignored. No queuing.
- `i_Binary` changes after capture have no effect on the running conversion.
- `o_BCD_Num` changes only on the edge entering DONE. It is never exposed mid-conversion.
- Overflow threshold is 10^DIGIT_NUM − 1, computed as a parameter constant. If 2^INPUT_WIDTH − 1 ≤ that threshold, overflow is unreachable and `o_Overflow` stays 0.
- Counter width is clog2(INPUT_WIDTH+1) bits.

## Timing
- Reset (edge with `i_Reset`=1): state IDLE, `o_BCD_Num`=0, `o_Busy`=0, `o_Done`=0, `o_Overflow`=0. Scratch, shift register and counter are cleared.
- Reset takes priority over everything, including a simultaneous `i_Start`.
- Reset mid-CONVERT aborts the conversion. `o_BCD_Num` returns to 0 and no `o_Done` is produced.
- Let edge k accept `i_Start`:
  - `o_Busy`=1 from after edge k.
  - Edges k+1 … k+INPUT_WIDTH each perform one step.
  - After edge k+INPUT_WIDTH: `o_Busy`=0, `o_Done`=1, new `o_BCD_Num` valid.
  - After edge k+INPUT_WIDTH+1: `o_Done`=0, state IDLE.
- Latency from accept edge to `o_Done` high is INPUT_WIDTH cycles (14 by default).
- Minimum accept-to-accept spacing is INPUT_WIDTH+2 edges (16 by default).
- `i_Start` held high continuously restarts one cycle after each DONE. The captured value is whatever `i_Binary` holds on that accepting edge.

## Test plan
- Reset, then `i_Binary`=1234 with a one-cycle `i_Start` → `o_Busy` high for 14 cycles, then `o_Done` pulses for exactly 1 cycle with `o_BCD_Num`=16'h1234 and `o_Overflow`=0.
- Boundary values 0, 9, 10, 999, 9999 → 16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h9999. `o_Overflow`=0 for all.
- Inputs 10000 and 16383 → `o_BCD_Num`=16'h9999, `o_Overflow`=1. A following conversion of 42 → 16'h0042 and `o_Overflow` returns to 0.
- Start 5678, pulse `i_Start` with `i_Binary`=1111 at cycles 3 and 14 after accept → both pulses ignored, result 16'h5678. `o_BCD_Num` stays at its previous value until the `o_Done` cycle.
- Start 4321, then assert `i_Reset` at cycle 7 → all outputs 0, no `o_Done`. A fresh start of 4321 afterwards yields 16'h4321 with normal latency.
- `i_Start` held high with `i_Binary` stepping 0…20 → a `o_Done` pulse every 16 cycles. Each result matches the BCD of the value present on its accepting edge.
